savestate_load_fifo: RTL and testbench

Load-direction savestate buffer: accepts 16-bit half-words streamed from the SD sector buffer during an active load period, packs each consecutive pair into one 32-bit word, and presents those words to the savestate bus with a show-ahead valid/read handshake. It sits between the SD buffer interface and the core's savestate loader, mirroring the save-direction FIFO. Low half-word arrives first, so the stream is the exact inverse of the save path's 32→16 split.

---
 rtl/savestate_load_fifo.sv | 117 +++++++++++
 tb/tb_savestate_load_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/savestate_load_fifo.sv
// Load-direction savestate buffer: packs pairs of 16-bit SD half-words (low half first)
// into 32-bit words and queues them in a show-ahead FIFO for the savestate loader.
module savestate_load_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     active,
    input  logic                     sd_buff_wr,
    input  logic [7:0]               sd_buff_addr,
    input  logic [15:0]              sd_buff_dout,
    output logic [31:0]              bus_in,
    output logic                     valid,
    input  logic                     read_en,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW:0]   count_q, count_d;
    logic          hi_q, hi_d;
    logic [15:0]   lowHalf_q, lowHalf_d;
    logic          activePrev_q;
    logic          overflow_q, overflow_d;

    logic          accepted;
    logic          activeRise;
    logic          hiEff;
    logic          pushReq;
    logic [31:0]   pushWord;
    logic          isFull;
    logic          push;
    logic          pop;
    logic          drop;

    assign accepted   = sd_buff_wr && active;
    assign activeRise = active && !activePrev_q;
    // Either edge of active, or a sector start (addr 0), realigns the packer to a low half.
    assign hiEff      = hi_q && (active == activePrev_q) && (sd_buff_addr != 8'd0);
    assign pushWord   = {sd_buff_dout, lowHalf_q};

    always_comb begin
        hi_d      = hi_q;
        lowHalf_d = lowHalf_q;
        pushReq   = 1'b0;
        if (active != activePrev_q) begin
            hi_d = 1'b0;
        end
        if (accepted) begin
            if (!hiEff) begin
                lowHalf_d = sd_buff_dout;
                hi_d      = 1'b1;
            end else begin
                pushReq = 1'b1;
                hi_d    = 1'b0;
            end
        end
    end

    assign isFull = (count_q == DEPTH_C);
    assign pop    = read_en && (count_q != '0);
    assign push   = pushReq && (!isFull || pop);
    assign drop   = pushReq && isFull && !pop;

    always_comb begin
        rdPtr_d    = rdPtr_q + PW'(pop);
        wrPtr_d    = wrPtr_q + PW'(push);
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        overflow_d = overflow_q;
        if (activeRise) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            count_q      <= '0;
            hi_q         <= 1'b0;
            lowHalf_q    <= '0;
            activePrev_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
            hi_q         <= hi_d;
            lowHalf_q    <= lowHalf_d;
            activePrev_q <= active;
            overflow_q   <= overflow_d;
        end
    end

    // Storage is not reset; valid/count guard every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= pushWord;
        end
    end

    assign bus_in   = mem_q[rdPtr_q];
    assign valid    = (count_q != '0);
    assign full     = isFull;
    assign overflow = overflow_q;
    assign count    = count_q;

endmodule

// File: tb/tb_savestate_load_fifo.sv
// Randomized and directed bench for savestate_load_fifo, compared every cycle
// against a queue-based model of the packer and FIFO.
module tb_savestate_load_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        active = 1'b0;
    logic        sd_buff_wr = 1'b0;
    logic [7:0]  sd_buff_addr = 8'd0;
    logic [15:0] sd_buff_dout = 16'd0;
    logic [31:0] bus_in;
    logic        valid;
    logic        read_en = 1'b0;
    logic        full;
    logic        overflow;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    savestate_load_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .active       (active),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .bus_in       (bus_in),
        .valid        (valid),
        .read_en      (read_en),
        .full         (full),
        .overflow     (overflow),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of words plus the pending-half state.
    logic [31:0] mq[$];
    logic        mHi = 1'b0;
    logic [15:0] mLow = 16'd0;
    logic        mPrev = 1'b0;
    logic        mOvf = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        logic [31:0] word;
        logic        wantPush;
        logic        doPop;
        int          n;
        if (!reset_n) begin
            mq.delete();
            mHi   = 1'b0;
            mLow  = 16'd0;
            mPrev = 1'b0;
            mOvf  = 1'b0;
        end else begin
            wantPush = 1'b0;
            word     = 32'd0;
            if (active && !mPrev) begin
                mHi  = 1'b0;
                mOvf = 1'b0;
            end
            if (!active && mPrev) mHi = 1'b0;
            if (sd_buff_wr && active) begin
                if (sd_buff_addr == 8'd0) mHi = 1'b0;
                if (!mHi) begin
                    mLow = sd_buff_dout;
                    mHi  = 1'b1;
                end else begin
                    word     = {sd_buff_dout, mLow};
                    wantPush = 1'b1;
                    mHi      = 1'b0;
                end
            end
            n     = mq.size();
            doPop = read_en && (n != 0);
            if (doPop) void'(mq.pop_front());
            if (wantPush) begin
                if (n < DEPTH || doPop) mq.push_back(word);
                else mOvf = 1'b1;
            end
            mPrev = active;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("valid", 32'(valid), 32'(mq.size() != 0));
        checkOutput("count", 32'(count), 32'(mq.size()));
        checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
        if (mq.size() != 0) checkOutput("bus_in", bus_in, mq[0]);
    end

    task automatic applyStimulus(input logic act, input logic wr, input logic [7:0] addr,
                                 input logic [15:0] dout, input logic rd);
        active       = act;
        sd_buff_wr   = wr;
        sd_buff_addr = addr;
        sd_buff_dout = dout;
        read_en      = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic popAndCheck(input string name, input logic [31:0] exp);
        checkOutput(name, bus_in, exp);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'd0, 1'b1);
    endtask

    logic [31:0] seqExp [4];

    initial begin
        seqExp[0] = 32'h0002_0001;
        seqExp[1] = 32'h0004_0003;
        seqExp[2] = 32'h0006_0005;
        seqExp[3] = 32'h0008_0007;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0, 16'd0, 1'b0);

        // Reset in the middle of a pair
        applyStimulus(1'b1, 1'b1, 8'd0, 16'h1111, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_valid", 32'(valid), 32'd0);
        checkOutput("midrst_count", 32'(count), 32'd0);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'd0, 16'hAAAA, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd1, 16'hBBBB, 1'b0);
        checkOutput("midrst_word", bus_in, 32'hBBBB_AAAA);
        checkOutput("midrst_valid1", 32'(valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'd0, 1'b1);

        // Sequential stream with continuous reading
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i), 16'(i + 1), 1'b1);
            if (i % 2 == 1) checkOutput("seq_word", bus_in, seqExp[i / 2]);
        end
        applyStimulus(1'b1, 1'b0, 8'd0, 16'd0, 1'b1);
        checkOutput("seq_ovf", 32'(overflow), 32'd0);

        // Fill past capacity
        applyStimulus(1'b0, 1'b0, 8'd0, 16'd0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(i), 16'(16'h10 + i), 1'b0);
        checkOutput("fill_count", 32'(count), 32'd4);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_ovf", 32'(overflow), 32'd1);
        popAndCheck("fill_w0", 32'h0011_0010);
        popAndCheck("fill_w1", 32'h0013_0012);
        popAndCheck("fill_w2", 32'h0015_0014);
        popAndCheck("fill_w3", 32'h0017_0016);
        checkOutput("fill_empty", 32'(valid), 32'd0);
        checkOutput("fill_ovf_hold", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'd0, 1'b0);
        checkOutput("ovf_clear", 32'(overflow), 32'd0);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 8'(i), 16'(16'h20 + i), 1'b0);
        checkOutput("pp_full", 32'(full), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'd8, 16'h0028, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd9, 16'h0029, 1'b1);
        checkOutput("pp_count", 32'(count), 32'd4);
        checkOutput("pp_ovf", 32'(overflow), 32'd0);
        popAndCheck("pp_w1", 32'h0023_0022);
        popAndCheck("pp_w2", 32'h0025_0024);
        popAndCheck("pp_w3", 32'h0027_0026);
        popAndCheck("pp_w4", 32'h0029_0028);
        checkOutput("pp_empty", 32'(count), 32'd0);

        // Sector realignment discards the stranded low half
        applyStimulus(1'b1, 1'b1, 8'd255, 16'h1234, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd0, 16'h5678, 1'b0);
        checkOutput("realign_none", 32'(count), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'd1, 16'h9ABC, 1'b0);
        checkOutput("realign_count", 32'(count), 32'd1);
        checkOutput("realign_word", bus_in, 32'h9ABC_5678);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'd0, 1'b1);

        // Gated writes and underflow pops
        applyStimulus(1'b1, 1'b1, 8'd0, 16'h00AA, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd1, 16'h00BB, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd2, 16'h0001, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd3, 16'h0002, 1'b0);
        checkOutput("gate_count", 32'(count), 32'd1);
        checkOutput("gate_word", bus_in, 32'h00BB_00AA);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'd0, 1'b1);
        checkOutput("uflow_count", 32'(count), 32'd0);
        checkOutput("uflow_valid", 32'(valid), 32'd0);

        // Randomized traffic with two read-pressure phases
        for (int phase = 0; phase < 2; phase++) begin
            logic        act;
            logic [7:0]  addr;
            act  = 1'b1;
            addr = 8'd0;
            for (int c = 0; c < 1500; c++) begin
                logic wr;
                logic rd;
                if ($urandom_range(0, 31) == 0) act = ~act;
                wr = ($urandom_range(0, 2) != 0);
                rd = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) addr = 8'($urandom_range(0, 255));
                if (c == 700 && phase == 1) begin
                    reset_n = 1'b0;
                    #2;
                    reset_n = 1'b1;
                end
                applyStimulus(act, wr, addr, 16'($urandom), rd);
                if (wr && act) addr = addr + 8'd1;
            end
        end

        applyStimulus(1'b0, 1'b0, 8'd0, 16'd0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
